mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, meaning the number of busy cycles for mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, meaning the number of busy cycles for div/divu.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port Start, input, 1 bit: an EX-stage operation is valid this cycle.
REQ-006 The block SHALL have port MDOp, input, 3 bits, encoded as follows:
- 000 none
- 001 mult
- 010 multu
- 011 div
- 100 divu
- 101 mthi
- 110 mtlo
- 111 none
REQ-007 The block SHALL have port A, input, 32 bits: forwarded rs operand.
REQ-008 The block SHALL have port B, input, 32 bits: forwarded rt operand.
REQ-009 The block SHALL have port Busy, output, 1 bit: registered; high while a mult/div is in progress.
REQ-010 The block SHALL have port HI_OUT, output, 32 bits: current HI register.
REQ-011 The block SHALL have port LO_OUT, output, 32 bits: current LO register.

Function
REQ-012 State machine SHALL have two states, IDLE and RUN, plus a down-counter cnt wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-013 A mult/multu/div/divu operation SHALL be accepted only when Start=1 and the state is IDLE, at rising edge N.
REQ-014 At acceptance, the block SHALL latch A, B and the op into internal registers, load cnt with MULT_CYCLES or DIV_CYCLES, and go to RUN.
REQ-015 Busy SHALL be 1 in cycles N+1 through N+MULT_CYCLES (mult) or N+DIV_CYCLES (div), and 0 in all other cycles.
REQ-016 At the edge ending the last busy cycle, HI/LO SHALL be written with the result, Busy SHALL fall, and the state SHALL return to IDLE; the new values are visible on HI_OUT/LO_OUT in the first non-busy cycle.
REQ-017 The result SHALL be computed only from the latched operands; changes on A/B during RUN SHALL have no effect.
REQ-018 mult SHALL compute the 64-bit two's-complement product of A and B, with HI = bits[63:32] and LO = bits[31:0].
REQ-019 multu SHALL compute the same 64-bit split as mult, but with unsigned operands.
REQ-020 div SHALL set LO = signed quotient truncated toward zero and HI = remainder, where the remainder carries the sign of the dividend.
REQ-021 divu SHALL set LO = unsigned quotient and HI = unsigned remainder.
REQ-022 For div with A=0x80000000 and B=0xFFFFFFFF, the result SHALL be LO=0x80000000 and HI=0x00000000.
REQ-023 For a divide with B=0, the unit SHALL still go busy for DIV_CYCLES, and HI/LO SHALL remain unchanged at completion.
REQ-024 mthi with Start=1 in IDLE SHALL write HI=A at that edge; Busy stays 0 and LO is unchanged.
REQ-025 mtlo with Start=1 in IDLE SHALL write LO=A at that edge; Busy stays 0 and HI is unchanged.
REQ-026 Start with any MDOp during RUN SHALL be ignored, including mthi/mtlo; the upstream hazard logic stalls these, and the block SHALL NOT queue them.
REQ-027 Start=1 with MDOp 000 or 111 SHALL have no effect.
REQ-028 An operation accepted at the same edge on which a previous operation completes is impossible, because Busy=1 implies RUN; acceptance SHALL require the IDLE state at that edge.
REQ-029 HI_OUT and LO_OUT SHALL be driven directly from the HI/LO registers with no combinational bypass; mfhi/mflo read them in EX.

Reset
REQ-030 When Reset=1 at a rising edge, HI=0, LO=0, Busy=0, cnt=0 and state=IDLE SHALL take effect after that edge.
REQ-031 Reset SHALL take priority over Start and over completion in the same cycle.
REQ-032 Reset asserted mid-RUN SHALL discard the pending result; HI/LO become 0 and no later write occurs.
REQ-033 Power-up initial value of HI and LO SHALL be 0, matching the reset state.

Verification
REQ-034 Scenario 1: mult with A=0xFFFFFFFE (-2), B=3 -> Busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-035 Scenario 2: multu with A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 Scenario 3: div with A=0xFFFFFFF9 (-7), B=2 -> Busy high for 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu with A=7, B=0 -> HI/LO unchanged after 10 busy cycles.
REQ-037 Scenario 4: mthi with A=0x12345678 while IDLE -> HI_OUT=0x12345678 in the next cycle, Busy stays 0; mtlo issued during a RUN -> LO unchanged.
REQ-038 Scenario 5: div with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-039 Scenario 6: multu started, Reset asserted in busy cycle 3 -> Busy=0 and HI=LO=0 from the next cycle, with no write at the original completion edge.

Source files
------------

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: mult/multu/div/divu into HI/LO, plus mthi/mtlo writes.
// Latency: mult MULT_CYCLES, div DIV_CYCLES busy cycles; mthi/mtlo take effect at the accepting edge.
// Backpressure: Busy high while running; any Start seen while running is dropped, never queued.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI_OUT,
  output logic [31:0] LO_OUT
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic [31:0]   hi, lo;

  logic          is_md, is_mul, accept, done;
  logic [31:0]   res_hi, res_lo;
  logic          res_wr;

  logic          mul_sgn, div_sgn;
  logic [63:0]   mul_a, mul_b, prod;
  logic [31:0]   a_mag, b_mag, dvd, dvs, q_u, r_u;

  assign is_md  = (MDOp == OP_MULT) || (MDOp == OP_MULTU) || (MDOp == OP_DIV) || (MDOp == OP_DIVU);
  assign is_mul = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
  assign accept = Start && (state == IDLE) && is_md;
  // Last busy cycle: the edge ending it writes HI/LO and drops Busy.
  assign done   = (state == RUN) && (cnt == CW'(1));

  assign Busy   = (state == RUN);
  assign HI_OUT = hi;
  assign LO_OUT = lo;

  // Next-state and down-counter control.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
          cnt_nxt   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end
      end
      RUN: begin
        if (done) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Operand/op capture at acceptance; later changes on A/B are ignored.
  always_ff @(posedge clk) begin
    if (Reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= MDOp;
      a_q  <= A;
      b_q  <= B;
    end
  end

  // Result datapath from latched operands. Signed divide runs on magnitudes,
  // which also makes 0x80000000 / -1 wrap to 0x80000000 remainder 0.
  always_comb begin
    mul_sgn = (op_q == OP_MULT);
    div_sgn = (op_q == OP_DIV);
    mul_a   = {{32{mul_sgn & a_q[31]}}, a_q};
    mul_b   = {{32{mul_sgn & b_q[31]}}, b_q};
    prod    = mul_a * mul_b;
    a_mag   = a_q[31] ? (~a_q + 32'd1) : a_q;
    b_mag   = b_q[31] ? (~b_q + 32'd1) : b_q;
    dvd     = div_sgn ? a_mag : a_q;
    dvs     = div_sgn ? b_mag : b_q;
    if (dvs == 32'd0) dvs = 32'd1;  // divide-by-zero result is discarded anyway
    q_u     = dvd / dvs;
    r_u     = dvd % dvs;
    res_hi  = hi;
    res_lo  = lo;
    res_wr  = 1'b0;
    case (op_q)
      OP_MULT, OP_MULTU: begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        res_wr = 1'b1;
      end
      OP_DIV: begin
        res_lo = (a_q[31] ^ b_q[31]) ? (~q_u + 32'd1) : q_u;
        res_hi = a_q[31] ? (~r_u + 32'd1) : r_u;
        res_wr = (b_q != 32'd0);
      end
      OP_DIVU: begin
        res_lo = q_u;
        res_hi = r_u;
        res_wr = (b_q != 32'd0);
      end
      default: res_wr = 1'b0;
    endcase
  end

  // HI/LO registers: reset wins, then completion, then mthi/mtlo in IDLE.
  always_ff @(posedge clk) begin
    if (Reset) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      if (res_wr) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if (Start && (state == IDLE)) begin
      if (MDOp == OP_MTHI) hi <= A;
      if (MDOp == OP_MTLO) lo <= A;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: busy timing, results, mthi/mtlo, reset behaviour.
module tb_mult_div_unit;

  logic        clk;
  logic        Reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI_OUT;
  logic [31:0] LO_OUT;

  int n_chk  = 0;
  int n_fail = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .Reset  (Reset),
    .Start  (Start),
    .MDOp   (MDOp),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .HI_OUT (HI_OUT),
    .LO_OUT (LO_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_hilo(input string tag, input logic [31:0] hi_e, input logic [31:0] lo_e);
    chk({tag, "_hi"}, HI_OUT, hi_e);
    chk({tag, "_lo"}, LO_OUT, lo_e);
  endtask

  // Issue a one-cycle Start, then scramble A/B; returns in first busy cycle.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    tick();
    Start = 1'b0;
    MDOp  = 3'b000;
    A     = 32'hA5A5_5A5A;
    B     = 32'h0000_0000;
  endtask

  // Expect Busy high for n cycles, then low in the following cycle.
  task automatic run_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, 32'(Busy), 32'd1);
      tick();
    end
    chk({tag, "_idle"}, 32'(Busy), 32'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a);
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    tick();
    Start = 1'b0;
    MDOp  = 3'b000;
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    MDOp  = 3'b000;
    A     = 32'd0;
    B     = 32'd0;
    tick();
    tick();
    chk("reset_busy", 32'(Busy), 32'd0);
    chk_hilo("reset", 32'h0, 32'h0);
    Reset = 1'b0;
    tick();

    // mult -2 * 3
    start_op(3'b001, 32'hFFFF_FFFE, 32'd3);
    chk_hilo("mult_hold", 32'h0, 32'h0);
    run_check("mult", 5);
    chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // multu max * max
    start_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_check("multu", 5);
    chk_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    // div -7 / 2
    start_op(3'b011, 32'hFFFF_FFF9, 32'd2);
    run_check("div", 10);
    chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // divu 7 / 0 leaves HI/LO alone
    start_op(3'b100, 32'd7, 32'd0);
    run_check("divu0", 10);
    chk_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // mthi / mtlo in IDLE
    issue(3'b101, 32'h1234_5678);
    chk("mthi_busy", 32'(Busy), 32'd0);
    chk_hilo("mthi", 32'h1234_5678, 32'hFFFF_FFFD);
    issue(3'b110, 32'hCAFE_F00D);
    chk("mtlo_busy", 32'(Busy), 32'd0);
    chk_hilo("mtlo", 32'h1234_5678, 32'hCAFE_F00D);

    // Starts during RUN are dropped (mtlo, mthi, mult)
    start_op(3'b001, 32'h0001_0000, 32'h0001_0000);
    issue(3'b110, 32'hDEAD_BEEF);
    chk("run_mtlo_busy", 32'(Busy), 32'd1);
    chk_hilo("run_mtlo", 32'h1234_5678, 32'hCAFE_F00D);
    issue(3'b101, 32'hBEEF_DEAD);
    Start = 1'b1;
    MDOp  = 3'b001;
    A     = 32'd3;
    B     = 32'd3;
    tick();
    Start = 1'b0;
    MDOp  = 3'b000;
    run_check("mult_ign", 2);
    chk_hilo("mult_ign", 32'h0000_0001, 32'h0000_0000);
    tick();
    chk("no_queue_busy", 32'(Busy), 32'd0);
    chk_hilo("no_queue", 32'h0000_0001, 32'h0000_0000);

    // MDOp 000 / 111 do nothing
    issue(3'b000, 32'h5555_5555);
    chk("nop0_busy", 32'(Busy), 32'd0);
    issue(3'b111, 32'h6666_6666);
    chk("nop7_busy", 32'(Busy), 32'd0);
    chk_hilo("nop", 32'h0000_0001, 32'h0000_0000);

    // div overflow case
    start_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("div_ovf", 10);
    chk_hilo("div_ovf", 32'h0000_0000, 32'h8000_0000);

    // div 7 / -2, divu 0xFFFFFFF9 / 2
    start_op(3'b011, 32'd7, 32'hFFFF_FFFE);
    run_check("div_negb", 10);
    chk_hilo("div_negb", 32'h0000_0001, 32'hFFFF_FFFD);
    start_op(3'b100, 32'hFFFF_FFF9, 32'd2);
    run_check("divu", 10);
    chk_hilo("divu", 32'h0000_0001, 32'h7FFF_FFFC);

    // Reset in busy cycle 3 of a multu, with an mthi competing
    start_op(3'b010, 32'hFFFF_FFFF, 32'd2);
    chk("rst_c1_busy", 32'(Busy), 32'd1);
    tick();
    chk("rst_c2_busy", 32'(Busy), 32'd1);
    tick();
    Reset = 1'b1;
    Start = 1'b1;
    MDOp  = 3'b101;
    A     = 32'h0000_0055;
    chk("rst_c3_busy", 32'(Busy), 32'd1);
    tick();
    Reset = 1'b0;
    Start = 1'b0;
    MDOp  = 3'b000;
    chk("rst_after_busy", 32'(Busy), 32'd0);
    chk_hilo("rst_after", 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_late_busy", 32'(Busy), 32'd0);
    chk_hilo("rst_late", 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
